ascon_out_serializer: RTL and testbench
=======================================

# ascon_out_serializer

Downstream consumer of the Ascon encryption core. It captures every 64-bit ciphertext block the core flags valid, latches the 128-bit tag when the core signals end of encryption, then streams ciphertext followed by tag as bytes over a valid/ready interface, most-significant byte first. It decouples the core's fixed-rate output from a slower byte-wide sink such as a UART or bus bridge.

## Interface
- MAX_BLOCKS, default 4: ciphertext blocks the buffer can hold (power of two, ≥2).
- clock_i  in  1  clock; all state changes on its rising edge.
- resetb_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  same pulse that starts the core; clears the buffer and flags, aborts any transfer.
- cipher_valid_i  in  1  cipher_i holds a valid block this cycle.
- cipher_i  in  64  ciphertext block.
- end_i  in  1  encryption finished; tag_i valid this cycle.
- tag_i  in  128  authentication tag.
- byte_ready_i  in  1  sink accepts byte_o this cycle.
- byte_valid_o  out  1  byte_o valid.
- byte_o  out  8  output byte.
- byte_last_o  out  1  byte_o is the final tag byte.
- busy_o  out  1  high from first captured block (or end_i) until the last byte transfers.
- overflow_o  out  1  sticky: a block was dropped.

## Operation
- States: IDLE, COLLECT, SEND_CIPHER, SEND_TAG.
- IDLE: cipher_valid_i stores the block in slot 0 and moves to COLLECT. end_i latches the tag and moves to SEND_TAG, with no ciphertext.
- COLLECT: each cipher_valid_i writes the next slot and increments the block count. On end_i, latch tag_i, then:
  - count > 0: go to SEND_CIPHER.
  - count = 0: go to SEND_TAG.
- cipher_valid_i and end_i in the same cycle: the block is stored first, then the tag is latched. The block is included in the count.
- Buffer full (count = MAX_BLOCKS) and cipher_valid_i: block dropped, overflow_o set.
- cipher_valid_i while in SEND_CIPHER or SEND_TAG: block dropped, overflow_o set.
- end_i outside IDLE/COLLECT: ignored.
- SEND_CIPHER: bytes go out in this order.
  - Blocks in arrival order.
  - Within a block, bits [63:56] first and bits [7:0] last.
  - A 3-bit byte index and a block read pointer advance on each transfer.
  - After byte 7 of the last stored block, go to SEND_TAG.
- SEND_TAG: 16 bytes, tag[127:120] first. A 4-bit index advances on each transfer. After byte 15 transfers, go to IDLE and clear the count.
- Transfer rule: a byte transfers in any cycle where byte_valid_o and byte_ready_i are both high.
- Total bytes per message: 8·count + 16.
- start_i has highest priority below reset. In any state, the next cycle is IDLE with:
  - count, pointers and byte indices = 0.
  - overflow_o = 0.
  - byte_valid_o = 0.
- overflow_o clears only on start_i or reset.

## Timing
- Reset values:
  - byte_valid_o = 0, byte_o = 0, byte_last_o = 0, busy_o = 0, overflow_o = 0.
  - State IDLE; all counters 0.
- Capture: a block on cycle t is in the buffer at t+1. Throughput is one block per cycle.
- Latency from end_i (cycle t) to byte_valid_o high: cycle t+1, with the first byte on byte_o. All outputs are registered.
- Sink stall: while byte_valid_o && !byte_ready_i, byte_o and byte_last_o hold stable.
- byte_valid_o never drops before its byte transfers, except on start_i or reset.
- With byte_ready_i held high: one byte per cycle, no bubbles, including the crossing between cipher and tag.
- byte_last_o is high only together with the 16th tag byte.
- After the last transfer, byte_valid_o and busy_o go low on the next cycle.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously). No partial byte is presented after reset is released.

## Structure
- ascon_pack gains:
  - ASCON_BLOCK_BYTES = 8 and ASCON_TAG_BYTES = 16.
  - The typedef enum type_out_state {IDLE, COLLECT, SEND_CIPHER, SEND_TAG}.
- One sub-module, ascon_block_buffer: MAX_BLOCKS×64 register file with write pointer, read pointer, count and full flag.
- The FSM, byte selection and the tag register live in the top of this block.
- Instantiated after ascon_top, with these connections:
  - cipher_valid_o → cipher_valid_i
  - cipher_o → cipher_i
  - end_o → end_i
  - tag_o → tag_i

## Test plan
- Single block, ready always high:
  - Stimulus: start_i, then cipher_i = 64'h0123456789ABCDEF, then end_i with tag_i = 128'h00112233445566778899AABBCCDDEEFF.
  - Response: 24 consecutive bytes 01 23 … EF 00 11 … FF; byte_last_o only on FF; busy_o low one cycle later.
- Backpressure:
  - Stimulus: same message as the single-block case; byte_ready_i toggles 1,0,0,1 repeatedly.
  - Response: identical byte sequence; byte_o stable through every stall.
- Overflow with MAX_BLOCKS = 4:
  - Stimulus: five blocks 64'h1…, 64'h2…, 64'h3…, 64'h4…, 64'h5…, then end_i.
  - Response: overflow_o high from the cycle after block 5; only blocks 1–4 sent; 48 bytes total.
- Tag only:
  - Stimulus: end_i from IDLE with no blocks.
  - Response: 16 tag bytes, byte_valid_o high at t+1.
- Simultaneous last block and end:
  - Stimulus: third block arrives in the same cycle as end_i.
  - Response: 40 bytes; the third block is sent before the tag.
- Abort:
  - Stimulus: start_i during SEND_TAG byte 5; then, in a separate run, resetb_i low during SEND_CIPHER.
  - start_i: byte_valid_o = 0 the next cycle, then a new message is accepted normally.
  - resetb_i: all outputs 0 immediately.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared constants, state type and byte-selection helpers for the Ascon output path.
package ascon_pack;

  localparam int unsigned ASCON_BLOCK_BYTES = 8;
  localparam int unsigned ASCON_TAG_BYTES   = 16;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND_CIPHER, SEND_TAG} type_out_state;

  // Byte idx of a block, counting from the most-significant byte.
  function automatic logic [7:0] block_byte(input logic [63:0] blk, input logic [2:0] idx);
    logic [63:0] sh;
    sh = blk << {idx, 3'b000};
    return sh[63:56];
  endfunction

  function automatic logic [7:0] tag_byte(input logic [127:0] tag, input logic [3:0] idx);
    logic [127:0] sh;
    sh = tag << {idx, 3'b000};
    return sh[127:120];
  endfunction

endpackage

// File: rtl/ascon_out_serializer_if.sv
// Core-side capture and byte-stream signals of the Ascon output serializer.
interface ascon_out_serializer_if;
  logic         start_i;
  logic         cipher_valid_i;
  logic [63:0]  cipher_i;
  logic         end_i;
  logic [127:0] tag_i;
  logic         byte_ready_i;
  logic         byte_valid_o;
  logic [7:0]   byte_o;
  logic         byte_last_o;
  logic         busy_o;
  logic         overflow_o;

  modport master (
    output start_i, cipher_valid_i, cipher_i, end_i, tag_i, byte_ready_i,
    input  byte_valid_o, byte_o, byte_last_o, busy_o, overflow_o
  );

  modport slave (
    input  start_i, cipher_valid_i, cipher_i, end_i, tag_i, byte_ready_i,
    output byte_valid_o, byte_o, byte_last_o, busy_o, overflow_o
  );
endinterface

// File: rtl/ascon_block_buffer.sv
// Ciphertext block store: write pointer, read pointer and count; writes beyond full are dropped.
module ascon_block_buffer #(
  parameter int unsigned  MAX_BLOCKS = 4,
  localparam int unsigned PtrW       = $clog2(MAX_BLOCKS),
  localparam int unsigned CntW       = PtrW + 1
) (
  input  logic            clock_i,
  input  logic            resetb_i,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [63:0]     wr_data,
  input  logic            rd_adv,
  output logic [63:0]     rd_data,
  output logic [63:0]     rd_next_data,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            rd_last
);

  logic [63:0]     mem_q [MAX_BLOCKS];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_wr;

  assign full  = (count_q == CntW'(MAX_BLOCKS));
  assign do_wr = wr_en && !full && !clear;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        count_q  <= count_q + CntW'(1);
      end
      if (rd_adv) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data      = mem_q[rd_ptr_q];
  assign rd_next_data = mem_q[rd_ptr_q + PtrW'(1)];
  assign count        = count_q;
  assign rd_last      = ({1'b0, rd_ptr_q} == (count_q - CntW'(1)));

endmodule

// File: rtl/ascon_out_serializer.sv
// Buffers Ascon ciphertext blocks and the tag, then streams them MSB-first as bytes.
module ascon_out_serializer
  import ascon_pack::*;
#(
  parameter int unsigned MAX_BLOCKS = 4
) (
  input logic                    clock_i,
  input logic                    resetb_i,
  ascon_out_serializer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_BLOCKS) + 1;

  type_out_state   state_q, state_d;
  logic [127:0]    tag_q, tag_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [3:0]      tag_idx_q, tag_idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_valid_q, byte_valid_d;
  logic            byte_last_q, byte_last_d;
  logic            busy_q;
  logic            overflow_q, overflow_d;
  logic            buf_clear, wr_en, rd_adv, full, rd_last, xfer;
  logic [63:0]     rd_data, rd_next_data;
  logic [CntW-1:0] count;

  ascon_block_buffer #(
    .MAX_BLOCKS (MAX_BLOCKS)
  ) u_buffer (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .clear        (buf_clear),
    .wr_en        (wr_en),
    .wr_data      (bus.cipher_i),
    .rd_adv       (rd_adv),
    .rd_data      (rd_data),
    .rd_next_data (rd_next_data),
    .count        (count),
    .full         (full),
    .rd_last      (rd_last)
  );

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    byte_idx_d   = byte_idx_q;
    tag_idx_d    = tag_idx_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    overflow_d   = overflow_q;
    buf_clear    = 1'b0;
    wr_en        = 1'b0;
    rd_adv       = 1'b0;
    xfer         = byte_valid_q && bus.byte_ready_i;

    if (bus.start_i) begin
      state_d      = IDLE;
      byte_idx_d   = '0;
      tag_idx_d    = '0;
      byte_d       = '0;
      byte_valid_d = 1'b0;
      byte_last_d  = 1'b0;
      overflow_d   = 1'b0;
      buf_clear    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, COLLECT: begin
          if (bus.cipher_valid_i) begin
            state_d = COLLECT;
            if (full) overflow_d = 1'b1;
            else      wr_en      = 1'b1;
          end
          // A block arriving with end_i is counted; its first byte bypasses the empty buffer.
          if (bus.end_i) begin
            tag_d        = bus.tag_i;
            byte_valid_d = 1'b1;
            byte_last_d  = 1'b0;
            if ((count != '0) || wr_en) begin
              state_d    = SEND_CIPHER;
              byte_idx_d = '0;
              byte_d     = (count == '0) ? bus.cipher_i[63:56] : rd_data[63:56];
            end else begin
              state_d   = SEND_TAG;
              tag_idx_d = '0;
              byte_d    = bus.tag_i[127:120];
            end
          end
        end
        SEND_CIPHER: begin
          if (bus.cipher_valid_i) overflow_d = 1'b1;
          if (xfer) begin
            if (byte_idx_q == 3'(ASCON_BLOCK_BYTES - 1)) begin
              byte_idx_d = '0;
              if (rd_last) begin
                state_d   = SEND_TAG;
                tag_idx_d = '0;
                byte_d    = tag_q[127:120];
              end else begin
                rd_adv = 1'b1;
                byte_d = rd_next_data[63:56];
              end
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
              byte_d     = block_byte(rd_data, byte_idx_q + 3'd1);
            end
          end
        end
        SEND_TAG: begin
          if (bus.cipher_valid_i) overflow_d = 1'b1;
          if (xfer) begin
            if (tag_idx_q == 4'(ASCON_TAG_BYTES - 1)) begin
              state_d      = IDLE;
              tag_idx_d    = '0;
              byte_d       = '0;
              byte_valid_d = 1'b0;
              byte_last_d  = 1'b0;
              buf_clear    = 1'b1;
            end else begin
              tag_idx_d   = tag_idx_q + 4'd1;
              byte_d      = tag_byte(tag_q, tag_idx_q + 4'd1);
              byte_last_d = (tag_idx_q + 4'd1 == 4'(ASCON_TAG_BYTES - 1));
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      byte_idx_q   <= '0;
      tag_idx_q    <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      byte_idx_q   <= byte_idx_d;
      tag_idx_q    <= tag_idx_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      busy_q       <= (state_d != IDLE);
      overflow_q   <= overflow_d;
    end
  end

  assign bus.byte_valid_o = byte_valid_q;
  assign bus.byte_o       = byte_q;
  assign bus.byte_last_o  = byte_last_q;
  assign bus.busy_o       = busy_q;
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_ascon_out_serializer.sv
// Directed and randomized bench for ascon_out_serializer against a message-level byte-queue model.
module tb_ascon_out_serializer;

  localparam int unsigned MAXB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_out_serializer_if bus ();

  ascon_out_serializer #(
    .MAX_BLOCKS (MAXB)
  ) dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int rmode = 0;
  int ph    = 0;

  // Message-level model: captured blocks, then a queue of bytes still to be sent.
  logic [63:0] m_blocks[$];
  logic [7:0]  m_q[$];
  bit          m_sending = 1'b0;
  bit          m_busy    = 1'b0;
  bit          m_ovf     = 1'b0;

  logic [7:0]  cap[$];
  int          last_pos[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_blocks.delete();
    m_q.delete();
    m_sending = 1'b0;
    m_busy    = 1'b0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n || bus.start_i) begin
      model_clear();
    end else if (m_sending) begin
      if (bus.cipher_valid_i) m_ovf = 1'b1;
      if (bus.byte_ready_i) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_sending = 1'b0;
          m_busy    = 1'b0;
        end
      end
    end else begin
      if (bus.cipher_valid_i) begin
        m_busy = 1'b1;
        if (m_blocks.size() < MAXB) m_blocks.push_back(bus.cipher_i);
        else                        m_ovf = 1'b1;
      end
      if (bus.end_i) begin
        foreach (m_blocks[b])
          for (int k = 0; k < 8; k++) m_q.push_back(m_blocks[b][63-8*k -: 8]);
        for (int k = 0; k < 16; k++) m_q.push_back(bus.tag_i[127-8*k -: 8]);
        m_blocks.delete();
        m_sending = 1'b1;
        m_busy    = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("byte_valid", 128'(bus.byte_valid_o), 128'(m_sending));
    if (m_sending) check("byte", 128'(bus.byte_o), 128'(m_q[0]));
    check("byte_last", 128'(bus.byte_last_o), 128'(m_sending && (m_q.size() == 1)));
    check("busy", 128'(bus.busy_o), 128'(m_busy));
    check("overflow", 128'(bus.overflow_o), 128'(m_ovf));
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && bus.byte_valid_o && bus.byte_ready_i) begin
      cap.push_back(bus.byte_o);
      if (bus.byte_last_o) last_pos.push_back(cap.size() - 1);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       bus.byte_ready_i = 1'b1;
      1:       begin bus.byte_ready_i = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
      default: bus.byte_ready_i = ($urandom_range(0, 2) != 0);
    endcase
  end

  function automatic logic [7:0] cap_at(input int i);
    return (i < cap.size()) ? cap[i] : 8'hxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic do_block(input logic [63:0] b);
    bus.cipher_valid_i = 1'b1;
    bus.cipher_i       = b;
    tick();
    bus.cipher_valid_i = 1'b0;
  endtask

  task automatic do_end(input logic [127:0] t);
    bus.end_i = 1'b1;
    bus.tag_i = t;
    tick();
    bus.end_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit stray);
    while (m_busy && budget > 0) begin
      if (stray && m_sending && m_q.size() > 3 && $urandom_range(0, 5) == 0) begin
        bus.cipher_valid_i = 1'b1;
        bus.cipher_i       = {$urandom, $urandom};
      end
      tick();
      bus.cipher_valid_i = 1'b0;
      budget--;
    end
    if (m_busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done: model still busy after cycle budget, required idle");
    end
    tick();
  endtask

  task automatic wait_remaining(input int rem);
    int budget = 200;
    while (!(m_sending && m_q.size() == rem) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_remaining: %0d bytes never reached, required reachable", rem);
    end
  endtask

  localparam logic [63:0]  C1 = 64'h0123456789ABCDEF;
  localparam logic [127:0] T1 = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    int nblk;
    bit simul;
    bus.start_i        = 1'b0;
    bus.cipher_valid_i = 1'b0;
    bus.cipher_i       = '0;
    bus.end_i          = 1'b0;
    bus.tag_i          = '0;
    bus.byte_ready_i   = 1'b1;

    #12;
    check("rst_valid", 128'(bus.byte_valid_o), 128'(0));
    check("rst_byte", 128'(bus.byte_o), 128'(0));
    check("rst_busy", 128'(bus.busy_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single block, ready held high.
    rmode = 0;
    do_start();
    cap.delete(); last_pos.delete();
    do_block(C1);
    do_end(T1);
    wait_done(200, 1'b0);
    check("single_len", 128'(cap.size()), 128'(24));
    check("single_b0", 128'(cap_at(0)), 128'(8'h01));
    check("single_b3", 128'(cap_at(3)), 128'(8'h67));
    check("single_b7", 128'(cap_at(7)), 128'(8'hEF));
    check("single_b8", 128'(cap_at(8)), 128'(8'h00));
    check("single_b15", 128'(cap_at(15)), 128'(8'h77));
    check("single_b23", 128'(cap_at(23)), 128'(8'hFF));
    check("single_nlast", 128'(last_pos.size()), 128'(1));
    if (last_pos.size() > 0) check("single_lastpos", 128'(last_pos[0]), 128'(23));

    // Backpressure 1,0,0,1.
    rmode = 1;
    ph    = 0;
    do_start();
    cap.delete();
    do_block(C1);
    do_end(T1);
    wait_done(400, 1'b0);
    check("bp_len", 128'(cap.size()), 128'(24));
    for (int k = 0; k < 8; k++) check("bp_cipher", 128'(cap_at(k)), 128'(8'h01 + 8'(8'h22 * k)));
    for (int k = 0; k < 16; k++) check("bp_tag", 128'(cap_at(8 + k)), 128'(8'(8'h11 * k)));

    // Overflow: five blocks into a four-deep buffer.
    rmode = 0;
    do_start();
    cap.delete();
    for (int i = 1; i <= 4; i++) do_block({16{4'(i)}});
    @(negedge clk);
    check("ovf_before", 128'(bus.overflow_o), 128'(0));
    do_block({16{4'h5}});
    @(negedge clk);
    check("ovf_after", 128'(bus.overflow_o), 128'(1));
    do_end(T1);
    wait_done(200, 1'b0);
    check("ovf_len", 128'(cap.size()), 128'(48));
    check("ovf_b0", 128'(cap_at(0)), 128'(8'h11));
    check("ovf_b31", 128'(cap_at(31)), 128'(8'h44));
    check("ovf_b32", 128'(cap_at(32)), 128'(8'h00));

    // Tag only, valid one cycle after end_i.
    do_start();
    cap.delete();
    do_end(T1);
    @(negedge clk);
    check("tagonly_valid", 128'(bus.byte_valid_o), 128'(1));
    check("tagonly_b0", 128'(bus.byte_o), 128'(8'h00));
    wait_done(200, 1'b0);
    check("tagonly_len", 128'(cap.size()), 128'(16));

    // Third block together with end_i.
    do_start();
    cap.delete();
    do_block(64'hAAAAAAAAAAAAAAAA);
    do_block(64'hBBBBBBBBBBBBBBBB);
    bus.cipher_valid_i = 1'b1;
    bus.cipher_i       = 64'hC0C1C2C3C4C5C6C7;
    do_end(T1);
    bus.cipher_valid_i = 1'b0;
    wait_done(200, 1'b0);
    check("simul_len", 128'(cap.size()), 128'(40));
    check("simul_b16", 128'(cap_at(16)), 128'(8'hC0));
    check("simul_b23", 128'(cap_at(23)), 128'(8'hC7));
    check("simul_b24", 128'(cap_at(24)), 128'(8'h00));

    // Abort with start_i while tag byte 5 is presented.
    do_start();
    do_block(C1);
    do_end(T1);
    wait_remaining(11);
    do_start();
    cap.delete();
    @(negedge clk);
    check("abort_valid", 128'(bus.byte_valid_o), 128'(0));
    check("abort_busy", 128'(bus.busy_o), 128'(0));
    do_block(C1);
    do_end(T1);
    wait_done(200, 1'b0);
    check("abort_len", 128'(cap.size()), 128'(24));

    // Asynchronous reset while ciphertext is streaming.
    do_start();
    do_block(C1);
    do_block(64'h1122334455667788);
    do_end(T1);
    wait_remaining(30);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(bus.byte_valid_o), 128'(0));
    check("arst_byte", 128'(bus.byte_o), 128'(0));
    check("arst_last", 128'(bus.byte_last_o), 128'(0));
    check("arst_busy", 128'(bus.busy_o), 128'(0));
    check("arst_ovf", 128'(bus.overflow_o), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cap.delete();
    do_block(C1);
    do_end(T1);
    wait_done(200, 1'b0);
    check("arst_len", 128'(cap.size()), 128'(24));
    check("arst_b0", 128'(cap_at(0)), 128'(8'h01));

    // Randomized messages with random backpressure and stray blocks.
    rmode = 2;
    for (int m = 0; m < 40; m++) begin
      do_start();
      nblk  = $urandom_range(0, 6);
      simul = (nblk > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < nblk; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        bus.cipher_valid_i = 1'b1;
        bus.cipher_i       = {$urandom, $urandom};
        if (simul && i == nblk - 1) begin
          bus.end_i = 1'b1;
          bus.tag_i = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
        bus.cipher_valid_i = 1'b0;
        bus.end_i          = 1'b0;
      end
      if (!simul) begin
        repeat ($urandom_range(0, 2)) tick();
        do_end({$urandom, $urandom, $urandom, $urandom});
      end
      wait_done(600, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
